// File: rtl/frame_reception.sv
// frame_reception: byte-wide MAC receiver. Strips preamble/SFD, captures the
// header, filters on destination, forwards payload without FCS through a
// 5-byte delay line, checks CRC-32 and reports per-frame status.
//
// Input handshake: rx_valid is a level that is high on every byte of a frame;
// there is no ready. A frame starts when rx_valid rises and ends on the first
// low cycle. Output pl_valid is a pulse per byte with no backpressure: the
// consumer must take every beat.
module frame_reception #(
  parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC     = 1'b0,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        hdr_valid,
  output logic [47:0] dest_addr,
  output logic [47:0] src_addr,
  output logic [15:0] eth_type,
  output logic        addr_match,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic        pl_last,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic        fmt_err,
  output logic [10:0] payload_len,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] CNT_MAX     = 11'(MAX_PAYLOAD + 4);
  localparam logic [10:0] MIN_LEN     = 11'(MIN_PAYLOAD);

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic          rx_valid_q;
  logic [2:0]    pre_cnt_q, pre_cnt_d;
  logic [3:0]    hdr_cnt_q, hdr_cnt_d;
  logic [103:0]  hdr_sr_q, hdr_sr_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [39:0]   line_q, line_d;     // newest byte in [7:0], oldest in [39:32]
  logic [31:0]   crc_q, crc_d;
  logic          err_fmt_q, err_fmt_d;
  logic          err_len_q, err_len_d;

  logic          hdr_valid_q, hdr_valid_d;
  logic [47:0]   dest_q, dest_d, src_q, src_d;
  logic [15:0]   type_q, type_d;
  logic          match_q, match_d;
  logic          pl_valid_q, pl_valid_d, pl_last_q, pl_last_d;
  logic [7:0]    pl_data_q, pl_data_d;
  logic          done_q, done_d, ok_q, ok_d;
  logic          crc_err_q, crc_err_d, len_err_q, len_err_d, fmt_err_q, fmt_err_d;
  logic [10:0]   plen_q, plen_d;

  logic          start, fend;
  logic [10:0]   cnt_inc, plen_calc;
  logic [111:0]  hdr_full;

  assign start     = rx_valid & ~rx_valid_q;
  assign fend      = ~rx_valid & rx_valid_q & (state_q != S_IDLE);
  assign cnt_inc   = cnt_q + 11'd1;
  assign plen_calc = (cnt_q >= 11'd4) ? (cnt_q - 11'd4) : 11'd0;
  assign hdr_full  = {hdr_sr_q, rx_data};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: frame end always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (fend) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: if (start) state_d = (rx_data == 8'h55) ? S_PRE : S_DROP;
        S_PRE: begin
          if (rx_data == 8'h55 && pre_cnt_q != 3'd7) state_d = S_PRE;
          else if (rx_data == 8'hD5)                 state_d = S_HDR;
          else                                       state_d = S_DROP;
        end
        S_HDR:   if (hdr_cnt_q == 4'd13) state_d = S_HDR == S_HDR ? S_PAY : S_HDR;
        S_PAY:   if (cnt_inc > CNT_MAX)  state_d = S_DROP;
        default: ;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    hdr_cnt_d   = hdr_cnt_q;
    hdr_sr_d    = hdr_sr_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    crc_d       = crc_q;
    err_fmt_d   = err_fmt_q;
    err_len_d   = err_len_q;
    hdr_valid_d = 1'b0;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    match_d     = match_q;
    pl_valid_d  = 1'b0;
    pl_data_d   = pl_data_q;
    pl_last_d   = 1'b0;
    done_d      = 1'b0;
    ok_d        = ok_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    fmt_err_d   = fmt_err_q;
    plen_d      = plen_q;

    if (fend) begin
      done_d    = 1'b1;
      plen_d    = plen_calc;
      fmt_err_d = err_fmt_q | (state_q == S_PRE) | (state_q == S_HDR);
      len_err_d = err_len_q | (plen_calc < MIN_LEN);
      crc_err_d = (state_q == S_PAY) & (crc_q != CRC_RESIDUE);
      ok_d      = match_q & ~crc_err_d & ~len_err_d & ~fmt_err_d;
      // The oldest delay-line byte is the final payload byte; the rest is FCS.
      if (state_q == S_PAY && match_q && cnt_q >= 11'd5) begin
        pl_valid_d = 1'b1;
        pl_last_d  = 1'b1;
        pl_data_d  = line_q[39:32];
      end
      pre_cnt_d = 3'd0;
      hdr_cnt_d = 4'd0;
      cnt_d     = 11'd0;
      line_d    = 40'd0;
      err_fmt_d = 1'b0;
      err_len_d = 1'b0;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pre_cnt_d = 3'd0;
            hdr_cnt_d = 4'd0;
            cnt_d     = 11'd0;
            line_d    = 40'd0;
            err_len_d = 1'b0;
            match_d   = 1'b0;
            if (rx_data == 8'h55) begin
              pre_cnt_d = 3'd1;
              err_fmt_d = 1'b0;
            end else begin
              err_fmt_d = 1'b1;
            end
          end
        end
        S_PRE: begin
          if (rx_data == 8'h55 && pre_cnt_q != 3'd7) begin
            pre_cnt_d = pre_cnt_q + 3'd1;
          end else if (rx_data == 8'hD5) begin
            crc_d     = 32'hFFFF_FFFF;
            hdr_cnt_d = 4'd0;
          end else begin
            err_fmt_d = 1'b1;
          end
        end
        S_HDR: begin
          crc_d     = crc_byte(crc_q, rx_data);
          hdr_sr_d  = {hdr_sr_q[95:0], rx_data};
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q == 4'd13) begin
            dest_d      = hdr_full[111:64];
            src_d       = hdr_full[63:16];
            type_d      = hdr_full[15:0];
            hdr_valid_d = 1'b1;
            match_d     = (hdr_full[111:64] == MAC_ADDR) |
                          (hdr_full[111:64] == 48'hFFFF_FFFF_FFFF) | PROMISC;
          end
        end
        S_PAY: begin
          crc_d  = crc_byte(crc_q, rx_data);
          cnt_d  = cnt_inc;
          line_d = {line_q[31:0], rx_data};
          if (cnt_q >= 11'd5 && match_q) begin
            pl_valid_d = 1'b1;
            pl_data_d  = line_q[39:32];
          end
          if (cnt_inc > CNT_MAX) err_len_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q  <= 1'b1;
      pre_cnt_q   <= 3'd0;
      hdr_cnt_q   <= 4'd0;
      hdr_sr_q    <= 104'd0;
      cnt_q       <= 11'd0;
      line_q      <= 40'd0;
      crc_q       <= 32'hFFFF_FFFF;
      err_fmt_q   <= 1'b0;
      err_len_q   <= 1'b0;
      hdr_valid_q <= 1'b0;
      dest_q      <= 48'd0;
      src_q       <= 48'd0;
      type_q      <= 16'd0;
      match_q     <= 1'b0;
      pl_valid_q  <= 1'b0;
      pl_data_q   <= 8'd0;
      pl_last_q   <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      fmt_err_q   <= 1'b0;
      plen_q      <= 11'd0;
    end else begin
      rx_valid_q  <= rx_valid;
      pre_cnt_q   <= pre_cnt_d;
      hdr_cnt_q   <= hdr_cnt_d;
      hdr_sr_q    <= hdr_sr_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      crc_q       <= crc_d;
      err_fmt_q   <= err_fmt_d;
      err_len_q   <= err_len_d;
      hdr_valid_q <= hdr_valid_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      match_q     <= match_d;
      pl_valid_q  <= pl_valid_d;
      pl_data_q   <= pl_data_d;
      pl_last_q   <= pl_last_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      fmt_err_q   <= fmt_err_d;
      plen_q      <= plen_d;
    end
  end

  assign hdr_valid   = hdr_valid_q;
  assign dest_addr   = dest_q;
  assign src_addr    = src_q;
  assign eth_type    = type_q;
  assign addr_match  = match_q;
  assign pl_valid    = pl_valid_q;
  assign pl_data     = pl_data_q;
  assign pl_last     = pl_last_q;
  assign frame_done  = done_q;
  assign frame_ok    = ok_q;
  assign crc_err     = crc_err_q;
  assign len_err     = len_err_q;
  assign fmt_err     = fmt_err_q;
  assign payload_len = plen_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_frame_reception.sv
// Bench for frame_reception: two instances (filtering and promiscuous) share
// one stimulus stream; expected header, payload and status records are queued
// as frames are built and popped when the DUTs produce them.
module tb_frame_reception;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int          MINP  = 46;
  localparam int          MAXP  = 1500;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic rx_valid;
  logic [7:0] rx_data;
  always #5 clk = ~clk;

  logic        hv0, am0, plv0, pll0, dn0, ok0, ce0, le0, fe0;
  logic [47:0] da0, sa0;
  logic [15:0] et0;
  logic [7:0]  pld0;
  logic [10:0] pln0;
  logic [2:0]  st0;
  logic        hv1, am1, plv1, pll1, dn1, ok1, ce1, le1, fe1;
  logic [47:0] da1, sa1;
  logic [15:0] et1;
  logic [7:0]  pld1;
  logic [10:0] pln1;
  logic [2:0]  st1;

  frame_reception #(.MAC_ADDR(MAC), .PROMISC(1'b0), .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .hdr_valid(hv0), .dest_addr(da0), .src_addr(sa0), .eth_type(et0), .addr_match(am0),
    .pl_valid(plv0), .pl_data(pld0), .pl_last(pll0), .frame_done(dn0), .frame_ok(ok0),
    .crc_err(ce0), .len_err(le0), .fmt_err(fe0), .payload_len(pln0), .dbg_state(st0));

  frame_reception #(.MAC_ADDR(MAC), .PROMISC(1'b1), .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .hdr_valid(hv1), .dest_addr(da1), .src_addr(sa1), .eth_type(et1), .addr_match(am1),
    .pl_valid(plv1), .pl_data(pld1), .pl_last(pll1), .frame_done(dn1), .frame_ok(ok1),
    .crc_err(ce1), .len_err(le1), .fmt_err(fe1), .payload_len(pln1), .dbg_state(st1));

  // scoreboard
  logic [8:0]   pl0_q[$];
  logic [8:0]   pl1_q[$];
  logic [112:0] hdr_q[$];
  logic [16:0]  st0_q[$];   // {mask_crc, mask_len, ok, crc, len, fmt, plen}
  logic [16:0]  st1_q[$];
  logic [7:0]   tx_q[$];
  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [16:0] st_rec(input bit mcrc, input bit mlen, input bit ok,
                                         input bit crc, input bit len, input bit fmt,
                                         input logic [10:0] pl);
    return {mcrc, mlen, ok, crc & ~mcrc, len & ~mlen, fmt, pl};
  endfunction

  // monitors (sample on falling edge)
  always @(negedge clk) begin : mon0
    logic [8:0] e9; logic [112:0] eh; logic [16:0] es;
    if (plv0) begin
      if (pl0_q.size() == 0) chk("pl0_extra", 128'(plv0), 128'(0));
      else begin e9 = pl0_q.pop_front(); chk("pl0_beat", 128'({pll0, pld0}), 128'(e9)); end
    end
    if (hv0) begin
      if (hdr_q.size() == 0) chk("hdr_extra", 128'(hv0), 128'(0));
      else begin eh = hdr_q.pop_front(); chk("hdr", 128'({da0, sa0, et0, am0}), 128'(eh)); end
    end
    if (dn0) begin
      if (st0_q.size() == 0) chk("st0_extra", 128'(dn0), 128'(0));
      else begin
        es = st0_q.pop_front();
        chk("status0", 128'({es[16], es[15], ok0, ce0 & ~es[16], le0 & ~es[15], fe0, pln0}), 128'(es));
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [8:0] e9; logic [16:0] es;
    if (plv1) begin
      if (pl1_q.size() == 0) chk("pl1_extra", 128'(plv1), 128'(0));
      else begin e9 = pl1_q.pop_front(); chk("pl1_beat", 128'({pll1, pld1}), 128'(e9)); end
    end
    if (dn1) begin
      if (st1_q.size() == 0) chk("st1_extra", 128'(dn1), 128'(0));
      else begin
        es = st1_q.pop_front();
        chk("status1", 128'({es[16], es[15], ok1, ce1 & ~es[16], le1 & ~es[15], fe1, pln1}), 128'(es));
      end
    end
  end

  // driver tasks
  task automatic drive_tx();
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
    end
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
  endtask

  task automatic push_head(input logic [47:0] dest, input logic [47:0] src,
                           input logic [15:0] et, output logic [31:0] c);
    logic [111:0] h;
    h = {dest, src, et};
    c = 32'hFFFF_FFFF;
    repeat (7) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 0; i < 14; i++) begin
      tx_q.push_back(h[111-8*i -: 8]);
      c = crc_upd(c, h[111-8*i -: 8]);
    end
  endtask

  task automatic send_frame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] et,
                            input int plen, input bit bad_fcs, input logic [7:0] pbase);
    logic [31:0] c; logic [7:0] b;
    bit m0, ovf, lerr, cerr; int nb; logic [10:0] pl_exp;
    push_head(dest, src, et, c);
    for (int i = 0; i < plen; i++) begin
      b = pbase + 8'(i);
      tx_q.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) begin
      b = c[8*i +: 8];
      if (bad_fcs && i == 3) b = b ^ 8'h01;
      tx_q.push_back(b);
    end
    m0     = (dest == MAC) || (dest == BCAST);
    ovf    = plen > MAXP;
    nb     = ovf ? MAXP : plen;
    pl_exp = ovf ? 11'(MAXP + 1) : 11'(plen);
    lerr   = ovf || (plen < MINP);
    cerr   = bad_fcs;
    hdr_q.push_back({dest, src, et, m0});
    for (int i = 0; i < nb; i++) begin
      if (m0) pl0_q.push_back({!ovf && (i == plen - 1), pbase + 8'(i)});
      pl1_q.push_back({!ovf && (i == plen - 1), pbase + 8'(i)});
    end
    st0_q.push_back(st_rec(ovf, 1'b0, m0 && !cerr && !lerr, cerr, lerr, 1'b0, pl_exp));
    st1_q.push_back(st_rec(ovf, 1'b0, !cerr && !lerr, cerr, lerr, 1'b0, pl_exp));
    drive_tx();
    idle(1);
  endtask

  initial begin
    logic [31:0] c;
    logic [47:0] src;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_pulses", 128'({hv0, plv0, pll0, dn0}), 128'(0));
    chk("rst_status", 128'({am0, ok0, ce0, le0, fe0, pln0}), 128'(0));
    chk("rst_hdr", 128'({da0, sa0, et0}), 128'(0));
    chk("rst_state", 128'(st0), 128'(0));
    rst = 1'b0;
    idle(2);

    // good broadcast frame, then corrupted FCS
    send_frame(BCAST, 48'hAABB_CCDD_EEFF, 16'h0800, 46, 1'b0, 8'h00);
    idle(2);
    send_frame(BCAST, 48'hAABB_CCDD_EEFF, 16'h0800, 46, 1'b1, 8'h00);
    idle(2);
    // filtered destination (promiscuous instance still delivers)
    send_frame(48'h0200_0000_0009, 48'h1122_3344_5566, 16'h86DD, 46, 1'b0, 8'($urandom_range(255, 0)));
    idle(2);
    // station address, random length
    src = {16'($urandom), $urandom};
    send_frame(MAC, src, 16'h0806, $urandom_range(80, 46), 1'b0, 8'($urandom_range(255, 0)));
    idle(2);
    // length errors
    send_frame(BCAST, src, 16'h0800, 20, 1'b0, 8'h40);
    idle(2);
    send_frame(BCAST, src, 16'h0800, 1501, 1'b0, 8'h10);
    idle(2);

    // truncated header: 10 header bytes then rx_valid drops
    repeat (7) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 0; i < 10; i++) tx_q.push_back(8'(i + 1));
    st0_q.push_back(st_rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0));
    st1_q.push_back(st_rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0));
    drive_tx();
    idle(3);

    // bad preamble byte, then a stream of bytes that must be ignored
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h33);
    for (int i = 0; i < 20; i++) tx_q.push_back(8'($urandom_range(255, 0)));
    st0_q.push_back(st_rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0));
    st1_q.push_back(st_rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0));
    drive_tx();
    idle(3);

    // reset mid-payload: 20 post-header bytes give 15 beats before reset
    push_head(BCAST, src, 16'h0800, c);
    hdr_q.push_back({BCAST, src, 16'h0800, 1'b1});
    for (int i = 0; i < 20; i++) begin
      tx_q.push_back(8'(8'h80 + i));
      if (i < 15) begin
        pl0_q.push_back({1'b0, 8'(8'h80 + i)});
        pl1_q.push_back({1'b0, 8'(8'h80 + i)});
      end
    end
    drive_tx();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rx_valid = 1'b1;
      rx_data  = (i == 0) ? 8'h55 : 8'($urandom_range(255, 0));
      @(negedge clk);
    end
    idle(1);
    chk("rst_abort_state", 128'(st0), 128'(0));

    // two good frames back-to-back with a single idle cycle
    send_frame(BCAST, src, 16'h0800, $urandom_range(70, 46), 1'b0, 8'($urandom_range(255, 0)));
    send_frame(MAC, src, 16'h0800, $urandom_range(70, 46), 1'b0, 8'($urandom_range(255, 0)));
    idle(20);

    chk("pl0_left", 128'(pl0_q.size()), 128'(0));
    chk("pl1_left", 128'(pl1_q.size()), 128'(0));
    chk("hdr_left", 128'(hdr_q.size()), 128'(0));
    chk("st0_left", 128'(st0_q.size()), 128'(0));
    chk("st1_left", 128'(st1_q.size()), 128'(0));
    chk("end_state", 128'(st0), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_reception.md
# frame_reception

Receive-side counterpart of the frame transmitter. It consumes a byte-wide MAC stream with preamble, SFD, destination, source, EtherType, payload and FCS, and framed by a data-valid level. It strips the preamble and SFD, captures the header fields and filters on destination address. It forwards payload bytes with FCS removed, checks the IEEE 802.3 CRC-32 and reports per-frame status. It sits between the PHY/loopback byte interface and the receive buffer.

## Interface
- MAC_ADDR, 48'h02_00_00_00_00_01: station address accepted by the filter.
- PROMISC, 0: 1 = accept every destination.
- MIN_PAYLOAD, 46: minimum legal payload bytes.
- MAX_PAYLOAD, 1500: maximum legal payload bytes.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  high on every cycle of a frame; the first low cycle ends the frame.
- rx_data  in  8  received byte.
- hdr_valid  out  1  one-cycle pulse: the 14 header bytes have been captured.
- dest_addr / src_addr  out  48 each  first byte received in bits [47:40]; held until the next header.
- eth_type  out  16  first byte received in bits [15:8]; held until the next header.
- addr_match  out  1  filter result, valid from hdr_valid until the next frame.
- pl_valid / pl_data / pl_last  out  1/8/1  payload byte stream, FCS excluded.
- frame_done  out  1  one-cycle end-of-frame pulse, with the status outputs below.
- frame_ok, crc_err, len_err, fmt_err  out  1 each  status, valid with frame_done.
- payload_len  out  11  payload byte count, valid with frame_done.

## Operation
- Frame start: only on rx_valid=1 with registered rx_valid_q=0. rx_valid_q resets to 1, so a stream already in progress at reset is ignored entirely.
- **IDLE**: on frame start the first byte must be 0x55, giving PREAMBLE; otherwise DROP with fmt_err.
- **PREAMBLE**:
  - 0x55 increments the preamble count.
  - 0xD5 after 1–7 preamble bytes gives HEADER.
  - Any other byte, or more than 7 preamble bytes, gives DROP with fmt_err.
- **HEADER**:
  - Shifts in 6 destination, 6 source and 2 EtherType bytes.
  - Pulses hdr_valid the cycle after the 14th byte is sampled.
  - addr_match = (dest==MAC_ADDR) | (dest==48'hFFFF_FFFF_FFFF) | PROMISC.
  - Then enters PAYLOAD.
- **PAYLOAD**:
  - Every byte enters a 5-byte delay line, and an 11-bit post-header counter increments.
  - When the line is full and a new byte arrives, the oldest byte is emitted: pl_valid=1, pl_last=0, only if addr_match.
  - When the counter exceeds MAX_PAYLOAD+4: go to DROP with len_err; nothing further is emitted and there is no pl_last.
- **DROP**: ignore bytes until rx_valid=0.
- **End of frame** (first rx_valid=0 after a start, from any non-IDLE state):
  - The 4 newest line bytes are the FCS.
  - The oldest byte is emitted with pl_last=1, if in PAYLOAD, addr_match=1 and the counter ≥5.
  - frame_done pulses. Return to IDLE, clear the delay line and counters.
- **CRC**:
  - Reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at the SFD, processed LSB first.
  - Covers every byte from destination through the last FCS byte.
  - crc_err = final register ≠ 0xDEBB20E3.
  - The transmitted FCS is the complemented CRC, least-significant byte first.
- **Status**:
  - payload_len = counter−4, saturating at 0.
  - len_err when payload_len < MIN_PAYLOAD or on overflow.
  - fmt_err when the frame ends in PREAMBLE or HEADER, or on a bad preamble. In that case crc_err=0 and hdr_valid never pulses.
  - frame_ok = addr_match & !crc_err & !len_err & !fmt_err.
  - A frame that ends in DROP still raises frame_done with its latched error.
- **Back-to-back**: one rx_valid=0 cycle between frames is sufficient; that idle cycle is the frame_done cycle.

## Timing
- All outputs are registered.
- Reset values: all pulses, status bits, payload_len, pl_*, hdr_valid and addr_match are 0; address/type registers are 0; state IDLE.
- Header latency: hdr_valid asserts 1 cycle after the 14th header byte is sampled.
- Payload latency: payload byte k is output the cycle after post-header byte k+5 is sampled.
- The last payload byte (with pl_last) and frame_done are output in the cycle after the first rx_valid=0 sample.
- No backpressure: the consumer must accept pl_valid on every cycle it is asserted.
- Reset mid-frame: the next cycle is quiet. No frame_done is issued for the aborted frame, and reception resumes only at the next rx_valid rising edge.

## Test plan
- **Good broadcast frame.**
  - Stimulus: 7×0x55, 0xD5, dest FF…FF, src AA_BB_CC_DD_EE_FF, type 0x0800, payload 0x00..0x2D (46 bytes), correct FCS from the bench model.
  - Required: hdr_valid; eth_type=0x0800; 46 pl beats 0x00..0x2D with pl_last on 0x2D; frame_ok=1; payload_len=46.
- **Corrupted FCS.** Stimulus: the same frame with the last FCS byte XOR 0x01. Required: identical payload stream; crc_err=1, frame_ok=0.
- **Filtered destination.** Stimulus: dest 02_00_00_00_00_09, PROMISC=0. Required: hdr_valid with addr_match=0; no pl_valid; frame_done with frame_ok=0. Repeat with PROMISC=1: payload is delivered.
- **Length errors.**
  - 20-byte payload: 20 beats, len_err=1, payload_len=20.
  - 1501-byte payload: exactly 1500 beats, no pl_last, len_err=1.
- **Format errors.**
  - rx_valid drops after 10 header bytes: frame_done with fmt_err=1, no hdr_valid.
  - Preamble byte 0x33: fmt_err=1 and no further activity until rx_valid falls.
- **Reset and back-to-back.**
  - Stimulus: rst pulsed mid-payload while rx_valid stays high for 30 more cycles, then a good frame, then a second good frame after a 1-cycle gap.
  - Required: nothing output for the aborted frame; both following frames have frame_ok=1.
